// File: rtl/store_buffer_if.sv
// Pipeline-side and dmem-side signals of the posted-write store buffer.
// slave = store buffer view, master = surrounding pipeline/dmem view.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          memwrite_i;
    logic          memread_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          stall_o;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic [CW-1:0] count_o;
    logic          empty_o;

    modport slave (
        input  memwrite_i, memread_i, addr_i, wdata_i, dmem_rdata,
        output rdata_o, stall_o, dmem_we, dmem_addr, dmem_wdata, count_o, empty_o
    );

    modport master (
        output memwrite_i, memread_i, addr_i, wdata_i, dmem_rdata,
        input  rdata_o, stall_o, dmem_we, dmem_addr, dmem_wdata, count_o, empty_o
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and dmem; loads forward from the youngest buffered store in 0 cycles,
// drains to dmem in non-load cycles (>=1 cycle after acceptance); stalls only a store arriving while full.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - 2;

    typedef struct packed {
        logic [WW-1:0] wordAddr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entries [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;

    logic          isEmpty;
    logic          isFull;
    logic          loadEn;
    logic          pushEn;
    logic          drainEn;
    logic          fwdHit;
    logic [DW-1:0] fwdData;
    logic [PW-1:0] scanIdx;
    entry_t        headEntry;

    assign isEmpty   = (count == '0);
    assign isFull    = (count == CW'(DEPTH));
    // A simultaneous load+store is handled as a store only.
    assign loadEn    = sb.memread_i & ~sb.memwrite_i;
    assign pushEn    = sb.memwrite_i & ~isFull;
    assign drainEn   = ~isEmpty & ~loadEn;
    assign headEntry = entries[headPtr];

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        scanIdx = headPtr;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = headPtr + PW'(i);
            if ((CW'(i) < count) && (entries[scanIdx].wordAddr == sb.addr_i[AW-1:2])) begin
                fwdHit  = 1'b1;
                fwdData = entries[scanIdx].data;
            end
        end
    end

    assign sb.stall_o    = sb.memwrite_i & isFull;
    assign sb.dmem_we    = drainEn;
    assign sb.dmem_addr  = drainEn ? {headEntry.wordAddr, 2'b00} : sb.addr_i;
    assign sb.dmem_wdata = headEntry.data;
    assign sb.rdata_o    = (loadEn & fwdHit) ? fwdData : sb.dmem_rdata;
    assign sb.count_o    = count;
    assign sb.empty_o    = isEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (pushEn) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (drainEn) begin
                headPtr <= headPtr + PW'(1);
            end
            count <= count + CW'(pushEn) - CW'(drainEn);
        end
    end

    // Entry payload needs no reset: validity is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            entries[tailPtr] <= '{wordAddr: sb.addr_i[AW-1:2], data: sb.wdata_i};
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: program-order memory model with a pending-store queue.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        miss;
    } ld_t;

    logic clk = 1'b0;
    logic reset;
    logic initMem;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sbIf ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sbIf)
    );

    always #5 clk = ~clk;

    logic [31:0] dmemArr      [256];
    logic [31:0] refCommitted [256];
    wr_t         writeQ[$];
    ld_t         loadQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          mCount     = 0;
    logic        expDrain;
    logic        expAccept;
    wr_t         expW;
    ld_t         expL;

    function automatic logic [31:0] initVal(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory behind the buffer: combinational read, write at the edge.
    assign sbIf.dmem_rdata = dmemArr[sbIf.dmem_addr[9:2]];
    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 256; i++) dmemArr[i] <= initVal(i);
        end else if (sbIf.dmem_we) begin
            dmemArr[sbIf.dmem_addr[9:2]] <= sbIf.dmem_wdata;
        end
    end

    // Monitor: occupancy follows the push/drain rules; writes and loads pop their queues.
    always @(negedge clk) begin
        if (reset) begin
            mCount = 0;
            if (initMem) begin
                for (int i = 0; i < 256; i++) refCommitted[i] = initVal(i);
            end
            check("rst_count", 32'(sbIf.count_o), 32'd0);
            check("rst_empty", 32'(sbIf.empty_o), 32'd1);
            check("rst_dmem_we", 32'(sbIf.dmem_we), 32'd0);
            check("rst_stall", 32'(sbIf.stall_o), 32'd0);
        end else begin
            assert (!(sbIf.memwrite_i && sbIf.memread_i))
                else $error("illegal simultaneous load and store driven");
            expDrain  = (mCount > 0) && !(sbIf.memread_i && !sbIf.memwrite_i);
            expAccept = sbIf.memwrite_i && (mCount < DEPTH);
            check("count", 32'(sbIf.count_o), 32'(mCount));
            check("empty", 32'(sbIf.empty_o), 32'(mCount == 0));
            check("stall", 32'(sbIf.stall_o), 32'(sbIf.memwrite_i && (mCount == DEPTH)));
            check("dmem_we", 32'(sbIf.dmem_we), 32'(expDrain));
            if (sbIf.dmem_we) begin
                if (writeQ.size() == 0) begin
                    check("dmem_we_unexpected", 32'(sbIf.dmem_we), 32'd0);
                end else begin
                    expW = writeQ.pop_front();
                    check("dmem_addr_wr", sbIf.dmem_addr, expW.addr);
                    check("dmem_wdata", sbIf.dmem_wdata, expW.data);
                    refCommitted[expW.addr[9:2]] = expW.data;
                end
            end
            if (sbIf.memread_i) begin
                if (loadQ.size() == 0) begin
                    check("load_unexpected", 32'(sbIf.memread_i), 32'd0);
                end else begin
                    expL = loadQ.pop_front();
                    check("rdata", sbIf.rdata_o, expL.data);
                    if (expL.miss) check("dmem_addr_ld", sbIf.dmem_addr, expL.addr);
                end
            end
            mCount = mCount + int'(expAccept) - int'(expDrain);
        end
    end

    task automatic setIdle();
        sbIf.memwrite_i = 1'b0;
        sbIf.memread_i  = 1'b0;
        sbIf.addr_i     = '0;
        sbIf.wdata_i    = '0;
    endtask

    task automatic doIdle();
        @(posedge clk); #1;
        setIdle();
        @(negedge clk);
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        int waitCycles;
        wr_t w;
        @(posedge clk); #1;
        sbIf.memwrite_i = 1'b1;
        sbIf.memread_i  = 1'b0;
        sbIf.addr_i     = a;
        sbIf.wdata_i    = d;
        w.addr = {a[31:2], 2'b00};
        w.data = d;
        writeQ.push_back(w);
        waitCycles = 0;
        @(negedge clk);
        while (sbIf.stall_o && waitCycles < 20) begin
            waitCycles++;
            @(negedge clk);
        end
        check("store_stall_bound", 32'(sbIf.stall_o), 32'd0);
    endtask

    task automatic doLoad(input logic [31:0] a);
        ld_t l;
        @(posedge clk); #1;
        sbIf.memwrite_i = 1'b0;
        sbIf.memread_i  = 1'b1;
        sbIf.addr_i     = a;
        sbIf.wdata_i    = '0;
        l.addr = a;
        l.miss = 1'b1;
        l.data = refCommitted[a[9:2]];
        for (int i = writeQ.size() - 1; i >= 0; i--) begin
            if (writeQ[i].addr[31:2] == a[31:2]) begin
                l.data = writeQ[i].data;
                l.miss = 1'b0;
                break;
            end
        end
        loadQ.push_back(l);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        setIdle();
        writeQ.delete();
        loadQ.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        initMem = 1'b1;
        setIdle();
        repeat (2) @(posedge clk);
        #1;
        initMem = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // Reset while a store is held in the buffer by loads: it must never reach dmem.
        doStore(32'h100, 32'h1111_1111);
        doLoad(32'h200);
        doLoad(32'h204);
        doReset();
        repeat (3) doIdle();
        check("discarded_store", dmemArr[32'h100 >> 2], initVal(32'h100 >> 2));

        // Single store drains in the following idle cycle.
        doStore(32'h40, 32'hAAAA_0001);
        repeat (3) doIdle();

        // Same-word stores: forwarding returns the younger one.
        doStore(32'h80, 32'h11);
        doStore(32'h80, 32'h22);
        doLoad(32'h80);
        repeat (3) doIdle();

        // Back-to-back stores with no loads.
        for (int i = 0; i < DEPTH + 1; i++) doStore(32'h300 + 32'(4 * i), $urandom());
        repeat (3) doIdle();

        // Loads to another word hold the buffered store; drain resumes afterwards.
        doStore(32'h100, 32'h5555_5555);
        repeat (3) doLoad(32'h200);
        repeat (3) doIdle();

        // Pointer wrap with loads to word 0 interleaved.
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            doStore(32'($urandom_range(0, 3)) << 2, $urandom());
            doLoad(32'h0);
        end

        // Random mix over a small address window to force frequent hits.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0:       doStore(32'($urandom_range(0, 15)) << 2, $urandom());
                1:       doLoad(32'($urandom_range(0, 15)) << 2);
                default: doIdle();
            endcase
        end

        repeat (DEPTH + 2) doIdle();
        check("final_empty", 32'(sbIf.empty_o), 32'd1);
        check("writes_outstanding", 32'(writeQ.size()), 32'd0);
        for (int i = 0; i < 256; i++) check("dmem_final", dmemArr[i], refCommitted[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
